// File: rtl/mem_responder_pkg.sv
// Shared definitions for the processor/memory bus endpoint: bus command
// encodings, tag width, and the delay-line entry format.
package mem_responder_pkg;

  localparam int XLEN      = 32;
  localparam int MEM_TAG_W = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_command_e;

  // One in-flight load: tag and the line snapshot taken at acceptance.
  typedef struct packed {
    logic                 valid;
    logic [MEM_TAG_W-1:0] tag;
    logic [63:0]          data;
  } mem_pipe_entry_t;

  // Tags run 1..15 and skip 0, which means "nothing" on the bus.
  function automatic logic [MEM_TAG_W-1:0] next_tag_after(input logic [MEM_TAG_W-1:0] t);
    return (t == 4'd15) ? 4'd1 : t + 4'd1;
  endfunction

endpackage

// File: rtl/mem_delay_line.sv
// Fixed-length shift register of load entries. It advances every cycle and
// never stalls; an asynchronous active-low reset empties every stage.
module mem_delay_line
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  mem_pipe_entry_t             in_entry,
  output mem_pipe_entry_t [DEPTH-1:0] stages,
  output mem_pipe_entry_t             out_entry
);

  mem_pipe_entry_t [DEPTH-1:0] stage_q;
  mem_pipe_entry_t [DEPTH-1:0] stage_d;

  // Stage 0 takes the new acceptance; every other stage takes its predecessor.
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = in_entry;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Clearing whole entries keeps tag and data at zero whenever valid is low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign stages    = stage_q;
  assign out_entry = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_responder.sv
// Memory-side endpoint of the processor/memory bus.
// Optional feature macro: MEM_RESPONDER_STALL_EN (adds the mem_stall input).
//
// Protocol: the requester drives proc2mem_command for one cycle. A LOAD is
// accepted in that same cycle iff mem2proc_response is nonzero (the tag);
// a STORE is always accepted unless stalled. The line for a load returns
// exactly MEM_LATENCY cycles later for one cycle, marked by mem2proc_tag.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int MEM_LATENCY    = 4,
  parameter int MEM_DEPTH_BITS = 13
) (
  input  logic            clock,
  input  logic            reset,
`ifdef MEM_RESPONDER_STALL_EN
  input  logic            mem_stall,
`endif
  input  logic [1:0]      proc2mem_command,
  input  logic [XLEN-1:0] proc2mem_addr,
  input  logic [63:0]     proc2mem_data,
  output logic [3:0]      mem2proc_response,
  output logic [63:0]     mem2proc_data,
  output logic [3:0]      mem2proc_tag
);

  logic [63:0] mem [2**MEM_DEPTH_BITS];

  logic [MEM_DEPTH_BITS-1:0] word_idx;
  logic                      stall_w;
  logic                      load_accept;
  logic                      store_accept;
  logic [MEM_TAG_W-1:0]      tag_q;
  logic [MEM_TAG_W-1:0]      tag_d;
  logic                      tag_live;
  mem_pipe_entry_t           in_entry;
  mem_pipe_entry_t           out_entry;
  mem_pipe_entry_t [MEM_LATENCY-1:0] stages;

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{proc2mem_addr[XLEN-1:MEM_DEPTH_BITS+3], proc2mem_addr[2:0]};

  assign word_idx = proc2mem_addr[MEM_DEPTH_BITS+2:3];

`ifdef MEM_RESPONDER_STALL_EN
  assign stall_w = mem_stall;
`else
  assign stall_w = 1'b0;
`endif

  // Reset low blocks acceptance so the response is forced to zero immediately.
  assign load_accept  = reset && !stall_w && (proc2mem_command == BUS_LOAD);
  assign store_accept = reset && !stall_w && (proc2mem_command == BUS_STORE);

  assign mem2proc_response = load_accept ? tag_q : 4'd0;

  // Next tag advances only when a load consumes the current one.
  always_comb begin
    tag_d = tag_q;
    if (load_accept) tag_d = next_tag_after(tag_q);
  end

  // Tag counter restarts at 1 on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) tag_q <= 4'd1;
    else        tag_q <= tag_d;
  end

  // Backing store; contents survive reset.
  always_ff @(posedge clock) begin
    if (store_accept) mem[word_idx] <= proc2mem_data;
  end

  // Snapshot the addressed line at acceptance so later stores cannot alter it.
  always_comb begin
    in_entry = '0;
    if (load_accept) begin
      in_entry.valid = 1'b1;
      in_entry.tag   = tag_q;
      in_entry.data  = mem[word_idx];
    end
  end

  mem_delay_line #(
    .DEPTH(MEM_LATENCY)
  ) u_delay_line (
    .clock    (clock),
    .reset    (reset),
    .in_entry (in_entry),
    .stages   (stages),
    .out_entry(out_entry)
  );

  assign mem2proc_tag  = out_entry.valid ? out_entry.tag  : 4'd0;
  assign mem2proc_data = out_entry.valid ? out_entry.data : 64'd0;

  // Flags whether the tag about to be issued is still in flight.
  always_comb begin
    tag_live = 1'b0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      if (stages[i].valid && (stages[i].tag == tag_q)) tag_live = 1'b1;
    end
  end

  tag_unique_a: assert property (@(posedge clock) disable iff (!reset)
    load_accept |-> !tag_live);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based model.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int LAT   = 4;
  localparam int DBITS = 13;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]      cmd       = 2'd0;
  logic [XLEN-1:0] addr      = '0;
  logic [63:0]     wdata     = '0;
  logic            mem_stall = 1'b0;
  logic [3:0]      response;
  logic [63:0]     rdata;
  logic [3:0]      rtag;

  mem_responder #(
    .MEM_LATENCY   (LAT),
    .MEM_DEPTH_BITS(DBITS)
  ) dut (
    .clock            (clock),
    .reset            (reset),
`ifdef MEM_RESPONDER_STALL_EN
    .mem_stall        (mem_stall),
`endif
    .proc2mem_command (cmd),
    .proc2mem_addr    (addr),
    .proc2mem_data    (wdata),
    .mem2proc_response(response),
    .mem2proc_data    (rdata),
    .mem2proc_tag     (rtag)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h (time %0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Expected beats as {due_cycle[31:0], tag[3:0], data[63:0]}, in issue order.
  logic [99:0] exp_q[$];
  logic [63:0] mem_m [0:(1<<DBITS)-1];
  int unsigned cyc      = 0;
  int unsigned model_tag = 1;

  function automatic int widx(input logic [XLEN-1:0] a);
    return int'((a >> 3) % (1 << DBITS));
  endfunction

  always @(negedge clock) begin
    logic [3:0]  e_resp;
    logic [3:0]  e_tag;
    logic [63:0] e_data;
    logic [99:0] head;
    logic        acc;
    e_resp = 4'd0;
    e_tag  = 4'd0;
    e_data = 64'd0;
    acc    = 1'b0;
    if (!reset) begin
      exp_q.delete();
      model_tag = 1;
    end else begin
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        if (head[99:68] == cyc) begin
          void'(exp_q.pop_front());
          e_tag  = head[67:64];
          e_data = head[63:0];
        end
      end
      acc = (cmd == 2'd1) && !mem_stall;
      if (acc) e_resp = 4'(model_tag);
    end
    chk("model_response", {60'd0, response}, {60'd0, e_resp});
    chk("model_tag",      {60'd0, rtag},     {60'd0, e_tag});
    chk("model_data",     rdata,             e_data);
    if (reset) begin
      if (acc) begin
        exp_q.push_back({32'(cyc + LAT), 4'(model_tag), mem_m[widx(addr)]});
        model_tag = (model_tag == 15) ? 1 : model_tag + 1;
      end
      if (cmd == 2'd2 && !mem_stall) mem_m[widx(addr)] = wdata;
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [1:0] c, input logic [XLEN-1:0] a, input logic [63:0] d);
    @(posedge clock);
    #1;
    cmd   = c;
    addr  = a;
    wdata = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'd0, '0, '0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    cmd   = 2'd0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] rnd;
    // Reset state with a LOAD presented: everything must read zero.
    cmd  = 2'd1;
    addr = 32'h100;
    @(negedge clock);
    chk("reset_response", {60'd0, response}, 64'd0);
    chk("reset_tag",      {60'd0, rtag},     64'd0);
    chk("reset_data",     rdata,             64'd0);
    do_reset();

    // Scenario 1: single load, latency 4.
    drive(2'd2, 32'h100, 64'hDEADBEEF_CAFEF00D);
    drive(2'd1, 32'h100, '0);
    @(negedge clock);
    chk("t1_response", {60'd0, response}, 64'd1);
    idle(4);
    @(negedge clock);
    chk("t1_beat_tag",  {60'd0, rtag}, 64'd1);
    chk("t1_beat_data", rdata, 64'hDEADBEEF_CAFEF00D);
    idle(1);
    @(negedge clock);
    chk("t1_after_tag",  {60'd0, rtag}, 64'd0);
    chk("t1_after_data", rdata, 64'd0);

    // Scenario 2: 16 back-to-back loads, tag wraps 15 -> 1.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      rnd = {$urandom, $urandom};
      drive(2'd2, 32'((64 + i) << 3), rnd);
    end
    for (int i = 0; i < 16; i++) begin
      drive(2'd1, 32'((64 + i) << 3), '0);
      @(negedge clock);
      chk("t2_response", {60'd0, response}, 64'((i % 15) + 1));
    end
    idle(6);

    // Scenario 3: store then load of the same word.
    do_reset();
    drive(2'd2, 32'h100, 64'h1111);
    @(negedge clock);
    chk("t3_store_response", {60'd0, response}, 64'd0);
    drive(2'd1, 32'h100, '0);
    @(negedge clock);
    chk("t3_load_response", {60'd0, response}, 64'd1);
    idle(4);
    @(negedge clock);
    chk("t3_beat_data", rdata, 64'h1111);

    // Scenario 4: load snapshot precedes a later store.
    do_reset();
    drive(2'd2, 32'h100, 64'hAAAA);
    drive(2'd1, 32'h100, '0);
    drive(2'd2, 32'h100, 64'hBBBB);
    idle(3);
    @(negedge clock);
    chk("t4_old_data", rdata, 64'hAAAA);
    chk("t4_old_tag",  {60'd0, rtag}, 64'd1);
    drive(2'd1, 32'h100, '0);
    @(negedge clock);
    chk("t4_second_response", {60'd0, response}, 64'd2);
    idle(4);
    @(negedge clock);
    chk("t4_new_data", rdata, 64'hBBBB);

    // Scenario 5: reset mid-flight drops the pending load.
    do_reset();
    drive(2'd1, 32'h100, '0);
    @(negedge clock);
    chk("t5_first_response", {60'd0, response}, 64'd1);
    idle(1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cmd   = 2'd1;
    @(negedge clock);
    chk("t5_rst_response", {60'd0, response}, 64'd0);
    chk("t5_rst_tag",      {60'd0, rtag},     64'd0);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("t5_rst2_data", rdata, 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    chk("t5_release_response", {60'd0, response}, 64'd1);
    chk("t5_dropped_beat_tag", {60'd0, rtag}, 64'd0);
    idle(6);

`ifdef MEM_RESPONDER_STALL_EN
    // Scenario 6: stalled load is rejected, retry gets the pending tag.
    do_reset();
    drive(2'd1, 32'h100, '0);
    idle(1);
    @(posedge clock);
    #1;
    cmd       = 2'd1;
    mem_stall = 1'b1;
    @(negedge clock);
    chk("t6_stalled_response", {60'd0, response}, 64'd0);
    @(posedge clock);
    #1;
    mem_stall = 1'b0;
    @(negedge clock);
    chk("t6_retry_response", {60'd0, response}, 64'd2);
    idle(6);
`endif

    // Randomized traffic over a preloaded window of 32 words.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      rnd = {$urandom, $urandom};
      drive(2'd2, 32'(i << 3), rnd);
    end
    for (int n = 0; n < 3000; n++) begin
      logic [XLEN-1:0] a;
      a = (32'($urandom_range(0, 65535)) << 16) | (32'($urandom_range(0, 31)) << 3)
          | 32'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) begin
        @(posedge clock);
        #1;
        reset = 1'b0;
        cmd   = 2'($urandom_range(0, 3));
        addr  = a;
        wdata = {$urandom, $urandom};
        repeat ($urandom_range(1, 3)) begin
          @(posedge clock);
          #1;
        end
        reset = 1'b1;
      end else begin
        drive(2'($urandom_range(0, 3)), a, {$urandom, $urandom});
`ifdef MEM_RESPONDER_STALL_EN
        mem_stall = ($urandom_range(0, 9) == 0);
`endif
      end
    end
    mem_stall = 1'b0;
    idle(LAT + 4);
    @(negedge clock);
    #1;

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
